// File: rtl/reg_file_id_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_id_if
// Description : Bundle of the WB write port, the ID read ports and the
//               debug dump stream for the ID-stage register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_id_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   // WB write port
   logic                  RegWrite_WB;
   logic [ADDR_WIDTH-1:0] Write_Reg;
   logic [DATA_WIDTH-1:0] Write_Data;
   // ID read ports
   logic [ADDR_WIDTH-1:0] Read_Reg1;
   logic [ADDR_WIDTH-1:0] Read_Reg2;
   logic [DATA_WIDTH-1:0] Read_Data1;
   logic [DATA_WIDTH-1:0] Read_Data2;
   // Debug dump stream
   logic                  dump_start;
   logic                  dump_ready;
   logic                  dump_valid;
   logic [ADDR_WIDTH-1:0] dump_addr;
   logic [DATA_WIDTH-1:0] dump_data;
   logic                  dump_busy;
   logic                  dump_done;

   // Pipeline / debug side
   modport master (
      output RegWrite_WB, Write_Reg, Write_Data, Read_Reg1, Read_Reg2,
             dump_start, dump_ready,
      input  Read_Data1, Read_Data2, dump_valid, dump_addr, dump_data,
             dump_busy, dump_done
   );

   // Register file side
   modport slave (
      input  RegWrite_WB, Write_Reg, Write_Data, Read_Reg1, Read_Reg2,
             dump_start, dump_ready,
      output Read_Data1, Read_Data2, dump_valid, dump_addr, dump_data,
             dump_busy, dump_done
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_id.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_id
// Description : ID-stage register file. Two combinational read ports with
//               same-cycle WB bypass, one synchronous WB write port, r0
//               hardwired to zero, and a handshaked engine that streams every
//               register to the debug unit.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_id #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  wire logic     clk,
   input  wire logic     reset,
   reg_file_id_if.slave  bus
);

   localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];

   state_t                state_q, state_d;
   logic                  dump_valid_q, dump_valid_d;
   logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
   logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
   logic                  dump_busy_q, dump_busy_d;
   logic                  dump_done_q, dump_done_d;

   logic                  wr_en;
   logic                  dump_xfer;
   logic [ADDR_WIDTH-1:0] dump_addr_inc;

   // Value a register will hold after the current edge; r0 never bypasses.
   function automatic logic [DATA_WIDTH-1:0] post_edge_value(
      input logic [ADDR_WIDTH-1:0] idx,
      input logic                  we,
      input logic [ADDR_WIDTH-1:0] wa,
      input logic [DATA_WIDTH-1:0] wd
   );
      if (idx == '0)
         return '0;
      else if (we && (wa == idx))
         return wd;
      else
         return regs_q[idx];
   endfunction

   assign wr_en         = bus.RegWrite_WB && (bus.Write_Reg != '0);
   assign dump_xfer     = dump_valid_q && bus.dump_ready;
   assign dump_addr_inc = dump_addr_q + 1'b1;

   assign bus.Read_Data1 = post_edge_value(bus.Read_Reg1, bus.RegWrite_WB,
                                           bus.Write_Reg, bus.Write_Data);
   assign bus.Read_Data2 = post_edge_value(bus.Read_Reg2, bus.RegWrite_WB,
                                           bus.Write_Reg, bus.Write_Data);

   assign bus.dump_valid = dump_valid_q;
   assign bus.dump_addr  = dump_addr_q;
   assign bus.dump_data  = dump_data_q;
   assign bus.dump_busy  = dump_busy_q;
   assign bus.dump_done  = dump_done_q;

   // Next register contents: single WB write, writes to r0 dropped.
   always_comb begin
      regs_d = regs_q;
      if (wr_en)
         regs_d[bus.Write_Reg] = bus.Write_Data;
   end

   // Register array storage, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Dump FSM next state and registered stream outputs.
   always_comb begin
      state_d      = state_q;
      dump_valid_d = dump_valid_q;
      dump_addr_d  = dump_addr_q;
      dump_data_d  = dump_data_q;
      dump_busy_d  = dump_busy_q;
      dump_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.dump_start) begin
               state_d      = SEND;
               dump_addr_d  = '0;
               dump_data_d  = '0;
               dump_valid_d = 1'b1;
               dump_busy_d  = 1'b1;
            end
         end
         SEND: begin
            if (dump_xfer) begin
               if (dump_addr_q == LAST_ADDR) begin
                  state_d      = DONE;
                  dump_valid_d = 1'b0;
                  dump_done_d  = 1'b1;
               end else begin
                  // Next word shows the register as it stands after this edge.
                  dump_addr_d = dump_addr_inc;
                  dump_data_d = post_edge_value(dump_addr_inc, bus.RegWrite_WB,
                                                bus.Write_Reg, bus.Write_Data);
               end
            end
         end
         DONE: begin
            state_d      = IDLE;
            dump_valid_d = 1'b0;
            dump_busy_d  = 1'b0;
            dump_addr_d  = '0;
            dump_data_d  = '0;
         end
         default: begin
            state_d      = IDLE;
            dump_valid_d = 1'b0;
            dump_busy_d  = 1'b0;
            dump_addr_d  = '0;
            dump_data_d  = '0;
         end
      endcase
   end

   // Dump FSM state and output registers; reset aborts any dump in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         dump_valid_q <= 1'b0;
         dump_addr_q  <= '0;
         dump_data_q  <= '0;
         dump_busy_q  <= 1'b0;
         dump_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dump_valid_q <= dump_valid_d;
         dump_addr_q  <= dump_addr_d;
         dump_data_q  <= dump_data_d;
         dump_busy_q  <= dump_busy_d;
         dump_done_q  <= dump_done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_id
// Description : Self-checking bench for reg_file_id. Directed scenarios plus
//               randomized traffic compared against a transaction-level model
//               (register array plus an expected word stream per dump).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_id;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic clk;
   logic reset;

   reg_file_id_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   reg_file_id #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: register contents and the dump transaction in flight.
   logic [DW-1:0] m_regs [DEPTH];
   bit            m_active;   // a dump is streaming words
   bit            m_finish;   // the one cycle after the last word
   int            m_word;     // index of word currently offered
   logic [DW-1:0] m_word_val; // its content, frozen when offered
   int            words_seen;

   task automatic check_val(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] idx);
      if (idx == 0) return '0;
      if (bus.RegWrite_WB && bus.Write_Reg == idx) return bus.Write_Data;
      return m_regs[idx];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_active   = 0;
      m_finish   = 0;
      m_word     = 0;
      m_word_val = '0;
      words_seen = 0;
   endtask

   // One clock: check reads before the edge, advance model, check dump after.
   task automatic tick();
      bit            we, st, acc;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      #1;
      check_val("rd1", bus.Read_Data1, exp_read(bus.Read_Reg1));
      check_val("rd2", bus.Read_Data2, exp_read(bus.Read_Reg2));
      we  = bus.RegWrite_WB;
      wa  = bus.Write_Reg;
      wd  = bus.Write_Data;
      st  = bus.dump_start;
      acc = m_active && bus.dump_ready;
      if (bus.dump_valid && bus.dump_ready) words_seen++;
      @(posedge clk);
      if (we && wa != 0) m_regs[wa] = wd;
      if (m_finish) begin
         m_finish = 0;
      end else if (m_active) begin
         if (acc) begin
            if (m_word == DEPTH - 1) begin
               m_active = 0;
               m_finish = 1;
            end else begin
               m_word++;
               m_word_val = m_regs[m_word];
            end
         end
      end else if (st) begin
         m_active   = 1;
         m_word     = 0;
         m_word_val = '0;
      end
      #1;
      check_val("valid", 32'(bus.dump_valid), 32'(m_active));
      check_val("busy",  32'(bus.dump_busy),  32'(m_active | m_finish));
      check_val("done",  32'(bus.dump_done),  32'(m_finish));
      if (m_active) begin
         check_val("daddr", 32'(bus.dump_addr), 32'(m_word));
         check_val("ddata", bus.dump_data, m_word_val);
      end
      if (bus.dump_done) begin
         check_val("nwords", 32'(words_seen), 32'(DEPTH));
         words_seen = 0;
      end
   endtask

   task automatic idle_inputs();
      bus.RegWrite_WB = 0;
      bus.Write_Reg   = '0;
      bus.Write_Data  = '0;
      bus.dump_start  = 0;
   endtask

   // Asynchronous reset asserted between edges; r5 read port must clear at once.
   task automatic do_reset();
      idle_inputs();
      bus.Read_Reg1 = 5'd5;
      #2;
      reset = 1'b1;
      #1;
      check_val("rst_rd5",   bus.Read_Data1, '0);
      check_val("rst_valid", 32'(bus.dump_valid), 0);
      check_val("rst_addr",  32'(bus.dump_addr), 0);
      check_val("rst_data",  bus.dump_data, '0);
      check_val("rst_busy",  32'(bus.dump_busy), 0);
      check_val("rst_done",  32'(bus.dump_done), 0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_dump_until_done(input int budget);
      int n = 0;
      while ((m_active || m_finish) && n < budget) begin
         tick();
         n++;
      end
      check_val("dump_ends", 32'(m_active | m_finish), 0);
   endtask

   initial begin
      model_clear();
      reset = 1'b1;
      idle_inputs();
      bus.Read_Reg1  = '0;
      bus.Read_Reg2  = '0;
      bus.dump_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("init_valid", 32'(bus.dump_valid), 0);
      check_val("init_busy",  32'(bus.dump_busy), 0);
      reset = 1'b0;

      // Reset mid-operation: r5 written then reset between edges.
      bus.RegWrite_WB = 1; bus.Write_Reg = 5'd5; bus.Write_Data = 32'hDEADBEEF;
      tick();
      idle_inputs();
      bus.Read_Reg1 = 5'd5;
      #1;
      check_val("r5_stored", bus.Read_Data1, 32'hDEADBEEF);
      #1;
      do_reset();

      // r0 protection, including the write cycle itself.
      bus.RegWrite_WB = 1; bus.Write_Reg = '0; bus.Write_Data = 32'hFFFFFFFF;
      bus.Read_Reg1 = '0; bus.Read_Reg2 = '0;
      tick();
      idle_inputs();
      tick();

      // Bypass on both ports, then persistence.
      bus.RegWrite_WB = 1; bus.Write_Reg = 5'd7; bus.Write_Data = 32'h11;
      tick();
      bus.Write_Data = 32'h22; bus.Read_Reg1 = 5'd7; bus.Read_Reg2 = 5'd7;
      #1;
      check_val("byp1", bus.Read_Data1, 32'h22);
      check_val("byp2", bus.Read_Data2, 32'h22);
      tick();
      idle_inputs();
      #1;
      check_val("hold1", bus.Read_Data1, 32'h22);
      check_val("hold2", bus.Read_Data2, 32'h22);
      tick();

      // Preload rN = N*3.
      for (int n = 1; n < DEPTH; n++) begin
         bus.RegWrite_WB = 1; bus.Write_Reg = AW'(n); bus.Write_Data = 32'(n * 3);
         tick();
      end
      idle_inputs();

      // Full dump with ready held high.
      bus.dump_ready = 1;
      bus.dump_start = 1;
      tick();
      bus.dump_start = 0;
      check_val("fd_valid1", 32'(bus.dump_valid), 1);
      check_val("fd_addr0",  32'(bus.dump_addr), 0);
      run_dump_until_done(40);
      tick();

      // Backpressure at word 2, same-edge write on advance at word 9.
      bus.dump_start = 1;
      tick();
      bus.dump_start = 0;
      for (int n = 0; n < 10 && m_word != 2; n++) tick();
      bus.dump_ready = 0;
      for (int n = 0; n < 4; n++) begin
         bus.RegWrite_WB = (n == 1);
         bus.Write_Reg   = 5'd2;
         bus.Write_Data  = 32'hAB;
         bus.dump_start  = (n == 2);
         tick();
         check_val("bp_addr", 32'(bus.dump_addr), 2);
         check_val("bp_data", bus.dump_data, 32'd6);
      end
      idle_inputs();
      bus.dump_ready = 1;
      tick();
      check_val("bp_next", bus.dump_data, 32'd9);
      for (int n = 0; n < 20 && m_word != 9; n++) tick();
      bus.RegWrite_WB = 1; bus.Write_Reg = 5'd10; bus.Write_Data = 32'h55;
      tick();
      idle_inputs();
      check_val("sw_addr", 32'(bus.dump_addr), 10);
      check_val("sw_data", bus.dump_data, 32'h55);
      bus.dump_start = 1;
      tick();
      bus.dump_start = 0;
      run_dump_until_done(40);
      // Back-to-back: start in the cycle right after DONE.
      bus.dump_start = 1;
      tick();
      bus.dump_start = 0;
      run_dump_until_done(40);

      // Reset in the middle of a dump: no done must follow.
      bus.dump_start = 1;
      tick();
      bus.dump_start = 0;
      for (int n = 0; n < 5; n++) tick();
      do_reset();
      for (int n = 0; n < 5; n++) tick();

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         bus.RegWrite_WB = 1'($urandom_range(0, 1));
         bus.Write_Reg   = AW'($urandom);
         bus.Write_Data  = $urandom;
         bus.Read_Reg1   = ($urandom_range(0, 3) == 0) ? bus.Write_Reg : AW'($urandom);
         bus.Read_Reg2   = ($urandom_range(0, 3) == 0) ? bus.Write_Reg : AW'($urandom);
         bus.dump_ready  = ($urandom_range(0, 3) != 0);
         bus.dump_start  = ($urandom_range(0, 19) == 0);
         tick();
      end
      idle_inputs();
      bus.dump_ready = 1;
      run_dump_until_done(80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_file_id.md
Name: reg_file_id

Overview:
- Register file on the read side of the write-back path: the WB stage mux result is written here, and the ID stage reads operands here.
- Provides 2 combinational read ports with same-cycle write-to-read bypass and 1 synchronous write port driven by WB.
- Register 0 is hardwired to zero.
- Includes a sequential dump engine that streams all registers, one per handshake, to the debug unit.

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- RegWrite_WB  input  1  write enable from WB.
- Write_Reg  input  ADDR_WIDTH  destination register from WB.
- Write_Data  input  DATA_WIDTH  WB mux result.
- Read_Reg1  input  ADDR_WIDTH  rs index from ID.
- Read_Reg2  input  ADDR_WIDTH  rt index from ID.
- Read_Data1  output  DATA_WIDTH  rs operand.
- Read_Data2  output  DATA_WIDTH  rt operand.
- dump_start  input  1  request a full register dump.
- dump_ready  input  1  debug unit accepts the current word.
- dump_valid  output  1  dump word valid.
- dump_addr  output  ADDR_WIDTH  index of the dump word.
- dump_data  output  DATA_WIDTH  dump word.
- dump_busy  output  1  dump in progress.
- dump_done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, active-high):
  - All registers clear to 0.
  - FSM goes to IDLE.
  - dump_valid=0, dump_addr=0, dump_data=0, dump_busy=0, dump_done=0.
  - Reset asserted mid-dump aborts the dump immediately; no dump_done is produced.
- Write:
  - On a rising clk edge with RegWrite_WB=1 and Write_Reg!=0, regs[Write_Reg] <= Write_Data.
  - A write with Write_Reg=0 is ignored.
- Read (combinational, zero latency):
  - If Read_RegN==0, Read_DataN=0.
  - Else if RegWrite_WB=1 and Write_Reg==Read_RegN, Read_DataN=Write_Data (bypass).
  - Else Read_DataN=regs[Read_RegN].
  - Both ports bypass independently; the same index on both ports gives the same value.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: dump_start=1 at an edge moves to SEND. dump_addr<=0, dump_data<=0 (reg 0), dump_valid<=1, dump_busy<=1. dump_valid is therefore high 1 cycle after dump_start.
  - SEND: a word transfers on an edge where dump_valid & dump_ready.
    - On a transfer with dump_addr<2**ADDR_WIDTH-1: dump_addr<=dump_addr+1, and dump_data<=the post-edge value of that register. If WB writes that register on the same edge, dump_data takes Write_Data. dump_valid stays 1.
    - On a transfer with dump_addr=2**ADDR_WIDTH-1: go to DONE with dump_valid<=0 and dump_done<=1.
    - Without a transfer, dump_addr and dump_data hold stable. A WB write to the held register does not alter dump_data.
  - DONE: lasts 1 cycle; dump_done=1, dump_busy=1. Next edge goes to IDLE with dump_done=0 and dump_busy=0.
  - dump_start is ignored in SEND and DONE; no queuing.
  - Back-to-back: dump_start asserted in the cycle after DONE starts a new dump.
- Full dump with dump_ready held at 1: 2**ADDR_WIDTH valid cycles, then 1 DONE cycle.
- Normal writes and reads continue unaffected during a dump.
- dump_addr wraps only through DONE/IDLE, never directly from 31 to 0 within SEND.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, assert reset asynchronously between edges -> Read_Data1 for r5 reads 0 immediately; all dump outputs are 0.
- r0 protection: RegWrite_WB=1, Write_Reg=0, Write_Data=0xFFFFFFFF; next cycle read r0 on both ports -> 0 on both, including during the write cycle (no bypass for r0).
- Bypass: r7=0x11 stored. Same cycle: write r7=0x22 and Read_Reg1=7, Read_Reg2=7 -> both ports read 0x22 combinationally. Next cycle with RegWrite_WB=0 -> both still read 0x22.
- Full dump, ready=1: preload rN=N*3. Pulse dump_start -> valid rises 1 cycle later. 32 consecutive words with addr 0..31 and data 0,3,...,93. dump_done pulses 1 cycle, then busy drops.
- Backpressure: dump with dump_ready=0 for 4 cycles while at addr 2; meanwhile WB writes r2=0xAB -> addr=2 and data=6 held stable. When ready=1, word 3 shows its current value.
- Same-edge write on advance: accept word 9 on the same edge WB writes r10=0x55 -> the next word is addr=10, data=0x55. dump_start pulsed mid-dump is ignored, so exactly 32 words are produced.
